// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the pipelined add/subtract unit.
//   op_e        operation encodings (ADD, SUB, ADC, reserved)
//   FLG_*       bit positions of the Z/C/N/V flags in the internal flag vector
//   width_legal parameter legality check: WIDTH must be a positive multiple of STAGE_W
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADC  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  localparam int FLG_Z  = 0;
  localparam int FLG_C  = 1;
  localparam int FLG_N  = 2;
  localparam int FLG_V  = 3;
  localparam int NFLAGS = 4;

  function automatic bit width_legal(input int width, input int stage_w);
    return (stage_w > 0) && (width >= stage_w) && ((width % stage_w) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: W-bit ripple of full-adder cells.
//   a, b      chunk operands
//   cin       carry into bit 0
//   sum       chunk sum
//   cout      carry out of the chunk MSB
//   c_msb_in  carry into the chunk MSB (used for signed overflow)
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract unit, one STAGE_W-bit chunk per stage.
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready = pipeline may advance)
//   op, a, b, cin         operation and operands
//   out_valid / out_ready result handshake
//   sum, carry, zero,     registered result and flags, valid while out_valid=1
//   neg, ovf
// Latency is NSTAGES = WIDTH/STAGE_W cycles; throughput one beat per cycle.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NSTAGES = WIDTH / STAGE_W;

  if (!width_legal(WIDTH, STAGE_W)) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a positive multiple of STAGE_W");
  end

  // Whole pipe moves together; a stalled output freezes every stage.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage-0 operand conditioning: SUB is a + ~b + 1.
  logic [WIDTH-1:0] b0;
  logic             c0;

  always_comb begin
    b0 = b;
    c0 = 1'b0;
    case (op_e'(op))
      OP_SUB: begin
        b0 = ~b;
        c0 = 1'b1;
      end
      OP_ADC:  c0 = cin;
      default: ;
    endcase
  end

  // Stage registers. a_r/b_r carry operands forward for the chunks still
  // to be summed; s_r holds the completed low chunks.
  logic [NSTAGES-1:0]            vld_r;
  logic [NSTAGES-1:0][WIDTH-1:0] a_r, b_r, s_r;
  logic [NSTAGES-1:0]            c_r;
  logic [NFLAGS-1:0]             flag_r;

  logic [NSTAGES-1:0][WIDTH-1:0] a_src, b_src, s_src, s_nx;
  logic [NSTAGES-1:0]            c_src, c_nx, msb_in;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic [STAGE_W-1:0] chunk_sum;

    if (k == 0) begin : g_first
      assign a_src[k] = a;
      assign b_src[k] = b0;
      assign s_src[k] = '0;
      assign c_src[k] = c0;
    end else begin : g_next
      assign a_src[k] = a_r[k-1];
      assign b_src[k] = b_r[k-1];
      assign s_src[k] = s_r[k-1];
      assign c_src[k] = c_r[k-1];
    end

    chunk_adder #(.W(STAGE_W)) u_chunk (
      .a        (a_src[k][k*STAGE_W +: STAGE_W]),
      .b        (b_src[k][k*STAGE_W +: STAGE_W]),
      .cin      (c_src[k]),
      .sum      (chunk_sum),
      .cout     (c_nx[k]),
      .c_msb_in (msb_in[k])
    );

    // Bits at and above chunk k of s_src are always zero, so OR-ing the new
    // chunk in place is equivalent to a slice insert.
    assign s_nx[k] = s_src[k] | (WIDTH'(chunk_sum) << (k * STAGE_W));
  end

  // Flags from the completed sum and the MSB carries of the final chunk.
  logic [NFLAGS-1:0] flags_nx;
  logic [WIDTH-1:0]  s_fin;

  assign s_fin = s_nx[NSTAGES-1];

  always_comb begin
    flags_nx        = '0;
    flags_nx[FLG_Z] = (s_fin == '0);
    flags_nx[FLG_C] = c_nx[NSTAGES-1];
    flags_nx[FLG_N] = s_fin[WIDTH-1];
    flags_nx[FLG_V] = c_nx[NSTAGES-1] ^ msb_in[NSTAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      c_r    <= '0;
      flag_r <= '0;
    end else if (advance) begin
      vld_r[0] <= in_valid;
      for (int i = 1; i < NSTAGES; i++) vld_r[i] <= vld_r[i-1];
      for (int i = 0; i < NSTAGES; i++) begin
        a_r[i] <= a_src[i];
        b_r[i] <= b_src[i];
        s_r[i] <= s_nx[i];
        c_r[i] <= c_nx[i];
      end
      flag_r <= flags_nx;
    end
  end

  assign out_valid = vld_r[NSTAGES-1];
  assign sum       = s_r[NSTAGES-1];
  assign carry     = flag_r[FLG_C];
  assign zero      = flag_r[FLG_Z];
  assign neg       = flag_r[FLG_N];
  assign ovf       = flag_r[FLG_V];

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for pipelined_addsub (WIDTH=16, STAGE_W=4).
module tb_pipelined_addsub;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry, zero, neg, ovf;

  pipelined_addsub #(.WIDTH(W), .STAGE_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c, z, n, v;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: integer arithmetic on the architectural definition.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci);
    exp_t e;
    int   ux, uy, uc, ures, sx, sy, sres;
    ux = int'(x);
    sx = int'($signed(x));
    case (o)
      2'b01: begin
        // a - b with carry meaning "no borrow"
        ures = ux + (65536 - int'(y));
        sres = sx - int'($signed(y));
      end
      2'b10: begin
        uc   = ci ? 1 : 0;
        uy   = int'(y);
        ures = ux + uy + uc;
        sres = sx + int'($signed(y)) + uc;
      end
      default: begin
        uy   = int'(y);
        ures = ux + uy;
        sres = sx + int'($signed(y));
      end
    endcase
    e.s = ures[W-1:0];
    e.c = (ures >= 65536);
    e.z = (ures[W-1:0] == 0);
    e.n = ures[W-1];
    e.v = (sres > 32767) || (sres < -32768);
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // Monitor: compares every delivered beat and checks hold during stalls.
  logic         prev_stall = 1'b0;
  logic [W+3:0] held;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if ({sum, carry, zero, neg, ovf} !== held || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b %h/%b%b%b%b, required v=1 %h/%b", out_valid, sum,
                   carry, zero, neg, ovf, held[W+3:4], held[3:0]);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got sum=%h, required no output", sum);
        end else begin
          e = q.pop_front();
          if (sum !== e.s || carry !== e.c || zero !== e.z || neg !== e.n || ovf !== e.v) begin
            n_fail++;
            $display("FAIL result: got sum=%h c=%b z=%b n=%b v=%b, required sum=%h c=%b z=%b n=%b v=%b",
                     sum, carry, zero, neg, ovf, e.s, e.c, e.z, e.n, e.v);
          end
          if (e.chk_lat) begin
            n_tests++;
            if (cyc - e.acc_cyc != LAT) begin
              n_fail++;
              $display("FAIL latency: got %0d cycles, required %0d", cyc - e.acc_cyc, LAT);
            end
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      held       = {sum, carry, zero, neg, ovf};
    end
  end

  task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input bit lat);
    exp_t e;
    int   tries = 0;
    bit   done  = 1'b0;
    op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(o, x, y, ci);
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        q.push_back(e);
        done = 1'b1;
      end else if (++tries > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", tries);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    idle();
    while (q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats outstanding, required 0", q.size());
    end
  endtask

  task automatic check_reset_state(input string name);
    n_tests++;
    if (out_valid !== 1'b0 || sum !== '0 || carry !== 1'b0 || zero !== 1'b0 || neg !== 1'b0 ||
        ovf !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got v=%b sum=%h c=%b z=%b n=%b o=%b rdy=%b, required all 0 and rdy=1",
               name, out_valid, sum, carry, zero, neg, ovf, in_ready);
    end
  endtask

  bit stim_done;

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset_state");
    @(posedge clk);
    #1;

    // Directed corner cases, no stall.
    send(2'b00, 16'h1234, 16'h0001, 1'b0, 1'b1);
    send(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    send(2'b01, 16'h8000, 16'h0001, 1'b0, 1'b1);
    send(2'b10, 16'h7FFF, 16'h0000, 1'b1, 1'b1);
    send(2'b01, 16'h0005, 16'h0005, 1'b0, 1'b1);
    send(2'b11, 16'h7FFF, 16'h0001, 1'b1, 1'b1);
    send(2'b10, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    send(2'b01, 16'h0000, 16'h0001, 1'b0, 1'b1);
    drain();

    // Back-to-back stream of 8 beats; fixed latency implies consecutive outputs.
    for (int i = 0; i < 8; i++)
      send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    drain();

    // Fill the pipe with out_ready low, hold 6 cycles, then release.
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++)
      send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL full_stall: got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    drain();

    // Randomised traffic with random backpressure.
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
          send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        end
        idle();
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three beats in flight.
    send(2'b00, 16'h1111, 16'h2222, 1'b0, 1'b0);
    send(2'b01, 16'h3333, 16'h0001, 1'b0, 1'b0);
    send(2'b10, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    idle();
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("mid_reset");
    @(posedge clk);
    #1;
    send(2'b00, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    drain();
    repeat (LAT + 2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
